// File: rtl/adc_frame_capture.sv
// adc_frame_capture
// Capture front-end between the ADC sampler and the analysis core.
// Accepted samples are optionally block-averaged per channel (DECIM samples
// summed, then shifted right by log2(DECIM)). The resulting beats are grouped
// into frames of FRAME_LEN beats and queued in an output FIFO.
//
// Ports:
//   clk, reset           system clock, asynchronous active-low reset
//   start / stop         single-cycle pulses: arm a capture / end continuous capture
//   adc_data, adc_data_valid, adc_channel   raw interleaved sample stream
//   out_data, out_channel, out_first, out_last, out_valid / out_ready
//                        framed output stream
//   busy                 FSM not idle or FIFO not empty
//   overrun              sticky: a beat was dropped because the FIFO was full
//   dbg_state            current FSM state (IDLE=0, ARM=1, CAPTURE=2, DRAIN=3)
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. out_valid and the beat fields are flop outputs that
// hold until the transfer; out_ready never reaches out_valid combinationally.

module adc_frame_capture #(
  parameter int DATA_W     = 12,
  parameter int NUM_CH     = 1,
  parameter int CH_W       = 3,
  parameter int DECIM      = 1,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int CONTINUOUS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_data_valid,
  input  logic [CH_W-1:0]   adc_channel,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_channel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int DEC_SH = $clog2(DECIM);
  localparam int ACC_W  = DATA_W + DEC_SH;
  localparam int CNT_W  = (DEC_SH > 0) ? DEC_SH : 1;
  localparam int FC_W   = $clog2(FRAME_LEN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int ENT_W  = DATA_W + CH_W + 2;

  localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam bit               CONT     = (CONTINUOUS != 0);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                stop_pend_q, stop_pend_d;
  logic                overrun_q, overrun_d;
  logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [ACC_W-1:0]    acc_q [NUM_CH];
  logic [ACC_W-1:0]    acc_d [NUM_CH];
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic [CNT_W-1:0]    cnt_d [NUM_CH];
  logic                beat_vld_q, beat_vld_d;
  logic [DATA_W-1:0]   beat_data_q, beat_data_d;
  logic [CH_W-1:0]     beat_ch_q, beat_ch_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    mem_cnt_q, mem_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [ENT_W-1:0]    out_ent_q, out_ent_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

  logic [OCC_W-1:0]    occ;
  logic                pop, fifo_full, ch_ok, accept, wr_en, load, is_first, is_last;
  logic [ENT_W-1:0]    wr_ent;
  logic [ACC_W-1:0]    sum;

  // The output register counts toward FIFO occupancy, so FIFO_DEPTH beats in
  // total can be held and out_valid rises one edge after the FIFO write.
  assign occ       = mem_cnt_q + OCC_W'(out_valid_q);
  assign pop       = out_valid_q && out_ready;
  assign fifo_full = (occ == OCC_FULL);
  assign ch_ok     = ({1'b0, adc_channel} < NUM_CH_V);
  // In ARM only a channel-0 sample may open the frame, keeping channels aligned.
  assign accept    = adc_data_valid && ch_ok &&
                     ((state_q == S_CAPTURE) || ((state_q == S_ARM) && (adc_channel == '0)));
  assign is_first  = (frame_cnt_q == '0);
  assign is_last   = (frame_cnt_q == FC_LAST);

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    beat_vld_d  = 1'b0;
    beat_data_d = beat_data_q;
    beat_ch_d   = beat_ch_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_ent_d   = out_ent_q;
    wr_en       = 1'b0;
    wr_ent      = '0;
    sum         = '0;
    load        = 1'b0;

    // Per-channel block averaging; the completed beat is registered one edge later.
    if (accept) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ({1'b0, adc_channel} == (CH_W + 1)'(c)) begin
          sum       = acc_q[c] + ACC_W'(adc_data);
          beat_ch_d = adc_channel;
          if ((DECIM == 1) || (cnt_q[c] == CNT_LAST)) begin
            beat_vld_d  = 1'b1;
            beat_data_d = (DECIM == 1) ? adc_data : sum[DEC_SH +: DATA_W];
            acc_d[c]    = '0;
            cnt_d[c]    = '0;
          end else begin
            acc_d[c] = sum;
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end
      end
    end

    // Beats only enter the FIFO while capturing; a beat finding the FIFO full
    // (with no simultaneous read) is dropped and does not count toward the frame.
    if (beat_vld_q && (state_q == S_CAPTURE)) begin
      if (fifo_full && !pop) begin
        overrun_d = 1'b1;
      end else begin
        wr_en       = 1'b1;
        wr_ent      = {is_first, is_last, beat_ch_q, beat_data_q};
        wr_ptr_d    = wr_ptr_q + 1'b1;
        frame_cnt_d = is_last ? '0 : frame_cnt_q + 1'b1;
      end
    end

    // Refill the output register whenever it is empty or being consumed.
    if (pop) out_valid_d = 1'b0;
    if ((!out_valid_q || pop) && (mem_cnt_q != '0)) begin
      load        = 1'b1;
      out_valid_d = 1'b1;
      out_ent_d   = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end
    mem_cnt_d = mem_cnt_q + OCC_W'(wr_en) - OCC_W'(load);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ARM;
          overrun_d   = 1'b0;
          stop_pend_d = 1'b0;
          frame_cnt_d = '0;
          for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = '0;
            cnt_d[c] = '0;
          end
        end
      end
      S_ARM: begin
        if (CONT && stop)  state_d = S_IDLE;
        else if (accept)   state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (CONT && stop) stop_pend_d = 1'b1;
        if (wr_en && is_last) begin
          if (!(CONT && !stop_pend_q && !stop)) begin
            state_d     = S_DRAIN;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: begin
        if ((mem_cnt_q == '0) && !out_valid_q) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      stop_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      beat_vld_q  <= 1'b0;
      beat_data_q <= '0;
      beat_ch_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_ent_q   <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      beat_vld_q  <= beat_vld_d;
      beat_data_q <= beat_data_d;
      beat_ch_q   <= beat_ch_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_ent_q   <= out_ent_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_ent;
  end

  assign {out_first, out_last, out_channel, out_data} = out_ent_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE) || (occ != '0);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: doc/adc_frame_capture.md
# adc_frame_capture

Parametrised capture front-end between the ADC sampler and the analysis core. It takes the raw `adc_data`/`adc_data_valid` stream and optionally decimates it by block-averaging per channel. It groups the result into fixed-length frames on `start` and delivers them through a FIFO with a valid/ready handshake. It supersedes the direct ADC-to-core connection and adds multi-channel, decimation, single-shot/continuous modes and backpressure.

## Interface

- `DATA_W`, 12: ADC sample width.
- `NUM_CH`, 1: interleaved channels, 1..8.
- `CH_W`, 3: width of channel index ports. Must be at least clog2(NUM_CH), minimum 1.
- `DECIM`, 1: decimation factor. Power of two, 1..64.
- `FRAME_LEN`, 1024: output beats per frame. Must be at least 2.
- `FIFO_DEPTH`, 16: output FIFO depth. Power of two, at least 4.
- `CONTINUOUS`, 0: 0 = single-shot, 1 = back-to-back frames until `stop`.
- `clk`, in, 1: system clock (MAX10_CLK1_50 domain).
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle pulse that arms a capture.
- `stop`, in, 1: single-cycle pulse that ends continuous capture after the current frame.
- `adc_data`, in, DATA_W: sample.
- `adc_data_valid`, in, 1: sample strobe, one cycle per sample.
- `adc_channel`, in, CH_W: channel of the current sample.
- `out_data`, out, DATA_W: decimated sample.
- `out_channel`, out, CH_W: channel of `out_data`.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: consumer accepts the beat.
- `out_first`, out, 1: first beat of a frame.
- `out_last`, out, 1: last beat of a frame.
- `busy`, out, 1: state is not IDLE, or the FIFO is not empty.
- `overrun`, out, 1: sticky flag, set when a sample is dropped.

## Operation

- **States:**
  - IDLE -> ARM on `start`.
  - ARM -> CAPTURE on the first accepted sample with `adc_channel` == 0. That sample is processed.
  - CAPTURE -> DRAIN when the FRAME_LEN-th beat is written.
  - DRAIN -> IDLE when the FIFO is empty (single-shot, or after `stop`).
  - CONTINUOUS=1: CAPTURE -> CAPTURE at the end of a frame, the frame counter restarts and the next beat is `out_first`. A `stop` seen during the frame is latched and forces DRAIN at the frame end.
- `start` outside IDLE is ignored. `stop` in IDLE or ARM returns to IDLE. `stop` in single-shot mode is ignored.
- **Decimation:**
  - One accumulator and one count per channel, each of width DATA_W+log2(DECIM), cleared on entry to ARM.
  - On the DECIM-th sample of a channel, output = (sum) >> log2(DECIM), truncated. The accumulator then restarts with zero.
  - DECIM=1: pass-through, no arithmetic.
- Samples with `adc_channel` >= NUM_CH are discarded silently.
- **Frame counter:** counts FIFO writes 0..FRAME_LEN-1. `out_first` and `out_last` are stored as FIFO sideband bits.
- **Overrun:**
  - A decimated beat that finds the FIFO full is dropped, sets `overrun`, and does not advance the frame counter. The frame still completes with FRAME_LEN written beats.
  - `overrun` clears only on an accepted `start`, or on reset.
- **FIFO:** a beat transfers when `out_valid` and `out_ready` are both high. Write and read in the same cycle while full is legal: the read frees the slot and the write succeeds.

## Timing

- **Reset values:**
  - All outputs 0: `out_valid`, `out_first`, `out_last`, `out_data`, `out_channel`, `busy`, `overrun`.
  - State IDLE, FIFO empty, accumulators 0.
- `busy` rises in the cycle after the `start` edge.
- **Latency:** with the DECIM-th sample accepted at edge N, the FIFO write occurs at edge N+1. If the FIFO was empty, `out_valid` is high after edge N+2.
- **Handshake:**
  - `out_valid` and `out_data` hold until accepted.
  - `out_ready` may toggle freely. There is no combinational path from `out_ready` to `out_valid`.
- Throughput is one beat per cycle.
- Reset asserted mid-frame discards all FIFO contents and partial accumulators immediately. There is no partial frame after release.

## Test plan

1. **Single-shot pass-through.** NUM_CH=1, DECIM=1, FRAME_LEN=4, `out_ready`=1, samples 10, 20, 30, 40, 50 after `start` -> beats 10, 20, 30, 40. `out_first` on 10, `out_last` on 40. 50 is not captured. `busy` falls once the FIFO empties.
2. **Averaging.** DECIM=4, samples 1, 2, 3, 5 -> one beat 2 (11>>2). Max-scale 4095 ×4 -> 4095, with no overflow.
3. **Two channels.** NUM_CH=2, DECIM=2. `start`, then ch1=7 (ignored in ARM), then ch0 = 4, 8 and ch1 = 2, 6 interleaved -> beats ch0=6 and ch1=4, in completion order.
4. **Backpressure and overrun.** FIFO_DEPTH=4, FRAME_LEN=8, `out_ready`=0 for 6 decimated beats -> 4 stored, `overrun`=1. After `out_ready`=1, 8 beats are delivered with the last flagged `out_last`. The next `start` clears `overrun`.
5. **Continuous mode.** CONTINUOUS=1, FRAME_LEN=3, 7 samples, with `stop` pulsed during the second frame -> frames [s0..s2], [s3..s5], then IDLE. s6 is not captured.
6. **Reset mid-frame.** `reset` low after 2 of 4 beats -> all outputs 0 immediately. A new `start` yields a full frame beginning with `out_first`.
